// File: rtl/csr_timer_int_ctrl_if.sv
// CSR access port between the WB stage (master) and the timer/interrupt block (slave).
interface csr_timer_int_ctrl_if;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_rvalue;
    logic        csr_hit;

    modport master (
        output csr_we, csr_num, csr_wmask, csr_wvalue,
        input  csr_rvalue, csr_hit
    );

    modport slave (
        input  csr_we, csr_num, csr_wmask, csr_wvalue,
        output csr_rvalue, csr_hit
    );
endinterface

// File: rtl/csr_timer_int_ctrl.sv
// Timer and interrupt scheduler: owns TID/TCFG/TVAL/TICLR and builds ESTAT.IS / has_int.
// Optional macro STABLE_COUNTER_EN adds a free-running 64-bit stable counter.
//
// state | meaning
// OFF   | timer disabled, TVAL holds
// COUNT | TVAL counting down, expiry at zero sets TI
// DONE  | one-shot expired, TVAL parked at all-ones, no further TI
module csr_timer_int_ctrl #(
    parameter logic [31:0] COREID  = 32'h0,
    parameter int          TIMER_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    csr_timer_int_ctrl_if.slave        bus,
    input  logic                       crmd_ie,
    input  logic [12:0]                ecfg_lie,
    input  logic [7:0]                 hw_int_in,
    input  logic                       ipi_int_in,
    output logic [12:0]                estat_is,
    output logic                       has_int,
    output logic [63:0]                stable_cnt
);
    localparam logic [13:0] CSR_ESTAT = 14'h005;
    localparam logic [13:0] CSR_TID   = 14'h040;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } timer_state_t;

    timer_state_t         state;
    logic [31:0]          tid;
    logic [TIMER_W-1:0]   tcfg;
    logic [TIMER_W-1:0]   tval;
    logic                 ti;
    logic [1:0]           sw;
    logic [7:0]           hw_q;
    logic                 ipi_q;

    logic                 wr_tid;
    logic                 wr_tcfg;
    logic                 wr_estat;
    logic                 ticlr_clr;
    logic                 expire;
    logic [31:0]          tid_new;
    logic [TIMER_W-1:0]   tcfg_new;
    logic [TIMER_W-1:0]   reload_new;
    logic [TIMER_W-1:0]   reload_cur;
    logic [1:0]           sw_new;

    always_comb begin
        wr_tid     = bus.csr_we && (bus.csr_num == CSR_TID);
        wr_tcfg    = bus.csr_we && (bus.csr_num == CSR_TCFG);
        wr_estat   = bus.csr_we && (bus.csr_num == CSR_ESTAT);
        ticlr_clr  = bus.csr_we && (bus.csr_num == CSR_TICLR)
                     && bus.csr_wvalue[0] && bus.csr_wmask[0];
        expire     = (state == ST_COUNT) && (tval == '0);
        tid_new    = (tid & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);
        tcfg_new   = (tcfg & ~bus.csr_wmask[TIMER_W-1:0])
                     | (bus.csr_wvalue[TIMER_W-1:0] & bus.csr_wmask[TIMER_W-1:0]);
        reload_new = {tcfg_new[TIMER_W-1:2], 2'b00};
        reload_cur = {tcfg[TIMER_W-1:2], 2'b00};
        sw_new     = (sw & ~bus.csr_wmask[1:0]) | (bus.csr_wvalue[1:0] & bus.csr_wmask[1:0]);
    end

    always_comb begin
        bus.csr_rvalue = 32'h0;
        case (bus.csr_num)
            CSR_TID:  bus.csr_rvalue = tid;
            CSR_TCFG: bus.csr_rvalue = 32'(tcfg);
            CSR_TVAL: bus.csr_rvalue = 32'(tval);
            default:  bus.csr_rvalue = 32'h0;
        endcase
        bus.csr_hit = (bus.csr_num == CSR_TID) || (bus.csr_num == CSR_TCFG)
                      || (bus.csr_num == CSR_TVAL) || (bus.csr_num == CSR_TICLR);
    end

    // A TCFG write overrides the state machine's own next TVAL/state, but an
    // expiry in the same cycle still raises TI, and expiry beats a TICLR clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_OFF;
            tcfg  <= '0;
            tval  <= '1;
            ti    <= 1'b0;
        end else begin
            if (expire) begin
                ti <= 1'b1;
            end else if (ticlr_clr) begin
                ti <= 1'b0;
            end

            if (wr_tcfg) begin
                tcfg <= tcfg_new;
                if (tcfg_new[0]) begin
                    tval  <= reload_new;
                    state <= ST_COUNT;
                end else begin
                    state <= ST_OFF;
                end
            end else begin
                case (state)
                    ST_COUNT: begin
                        if (tval != '0) begin
                            tval <= tval - TIMER_W'(1);
                        end else if (tcfg[1]) begin
                            tval <= reload_cur;
                        end else begin
                            tval  <= '1;
                            state <= ST_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tid   <= COREID;
            sw    <= 2'b00;
            hw_q  <= 8'h00;
            ipi_q <= 1'b0;
        end else begin
            if (wr_tid) begin
                tid <= tid_new;
            end
            if (wr_estat) begin
                sw <= sw_new;
            end
            hw_q  <= hw_int_in;
            ipi_q <= ipi_int_in;
        end
    end

    assign estat_is = {ipi_q, ti, 1'b0, hw_q, sw};
    assign has_int  = crmd_ie && (|(estat_is & ecfg_lie));

`ifdef STABLE_COUNTER_EN
    logic [63:0] stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= 64'h0;
        end else begin
            stable_q <= stable_q + 64'd1;
        end
    end

    assign stable_cnt = stable_q;
`else
    assign stable_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_csr_timer_int_ctrl.sv
// Directed self-checking bench for csr_timer_int_ctrl.
module tb_csr_timer_int_ctrl;
    localparam logic [13:0] CSR_ESTAT = 14'h005;
    localparam logic [13:0] CSR_TID   = 14'h040;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    logic        clk;
    logic        reset;
    logic        crmd_ie;
    logic [12:0] ecfg_lie;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [12:0] estat_is;
    logic        has_int;
    logic [63:0] stable_cnt;

    int compared   = 0;
    int mismatched = 0;

    csr_timer_int_ctrl_if csr_bus ();

    csr_timer_int_ctrl #(
        .COREID  (32'h0),
        .TIMER_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (csr_bus),
        .crmd_ie    (crmd_ie),
        .ecfg_lie   (ecfg_lie),
        .hw_int_in  (hw_int_in),
        .ipi_int_in (ipi_int_in),
        .estat_is   (estat_is),
        .has_int    (has_int),
        .stable_cnt (stable_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_csr(input logic [13:0] num, output logic [31:0] data);
        csr_bus.csr_num = num;
        #1;
        data = csr_bus.csr_rvalue;
    endtask

    task automatic csr_write(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        csr_bus.csr_we     = 1'b1;
        csr_bus.csr_num    = num;
        csr_bus.csr_wmask  = mask;
        csr_bus.csr_wvalue = val;
        tick();
        csr_bus.csr_we     = 1'b0;
        csr_bus.csr_wmask  = 32'h0;
        csr_bus.csr_wvalue = 32'h0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        crmd_ie    = 1'b0;
        ecfg_lie   = 13'h0;
        hw_int_in  = 8'h0;
        ipi_int_in = 1'b0;
        csr_bus.csr_we     = 1'b0;
        csr_bus.csr_num    = 14'h0;
        csr_bus.csr_wmask  = 32'h0;
        csr_bus.csr_wvalue = 32'h0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        read_csr(CSR_TID, rd);
        compared++;
        if (rd !== 32'h0) begin mismatched++; $display("FAIL reset_tid got %h exp %h", rd, 32'h0); end
        read_csr(CSR_TCFG, rd);
        compared++;
        if (rd !== 32'h0) begin mismatched++; $display("FAIL reset_tcfg got %h exp %h", rd, 32'h0); end
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL reset_tval got %h exp %h", rd, 32'hFFFF_FFFF); end
        compared++;
        if (estat_is !== 13'h0 || has_int !== 1'b0) begin
            mismatched++; $display("FAIL reset_estat got is=%h int=%b exp is=0 int=0", estat_is, has_int);
        end
        read_csr(CSR_TID, rd);
        compared++;
        if (csr_bus.csr_hit !== 1'b1) begin mismatched++; $display("FAIL hit_tid got %b exp 1", csr_bus.csr_hit); end
        read_csr(CSR_ESTAT, rd);
        compared++;
        if (csr_bus.csr_hit !== 1'b0 || rd !== 32'h0) begin
            mismatched++; $display("FAIL hit_estat got hit=%b rd=%h exp hit=0 rd=0", csr_bus.csr_hit, rd);
        end
        csr_write(CSR_TID, 32'hFFFF_0000, 32'h1234_5678);
        read_csr(CSR_TID, rd);
        compared++;
        if (rd !== 32'h1234_0000) begin mismatched++; $display("FAIL tid_masked got %h exp %h", rd, 32'h1234_0000); end
    endtask

    task automatic test_periodic();
        logic [31:0] rd;
        do_reset();
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'd8) begin mismatched++; $display("FAIL per_load got %0d exp 8", rd); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            read_csr(CSR_TVAL, rd);
            compared++;
            if (rd !== 32'(8 - k) || estat_is[11] !== 1'b0) begin
                mismatched++; $display("FAIL per_count k=%0d got tval=%0d ti=%b exp tval=%0d ti=0", k, rd, estat_is[11], 8 - k);
            end
        end
        tick();
        read_csr(CSR_TVAL, rd);
        compared++;
        if (estat_is[11] !== 1'b1 || rd !== 32'd8) begin
            mismatched++; $display("FAIL per_expire got ti=%b tval=%0d exp ti=1 tval=8", estat_is[11], rd);
        end
        csr_write(CSR_TICLR, 32'h1, 32'h1);
        read_csr(CSR_TVAL, rd);
        compared++;
        if (estat_is[11] !== 1'b0 || rd !== 32'd7) begin
            mismatched++; $display("FAIL per_clear got ti=%b tval=%0d exp ti=0 tval=7", estat_is[11], rd);
        end
        for (int k = 0; k < 7; k++) tick();
        compared++;
        if (estat_is[11] !== 1'b0) begin mismatched++; $display("FAIL per_early got ti=%b exp 0", estat_is[11]); end
        tick();
        read_csr(CSR_TVAL, rd);
        compared++;
        if (estat_is[11] !== 1'b1 || rd !== 32'd8) begin
            mismatched++; $display("FAIL per_second got ti=%b tval=%0d exp ti=1 tval=8", estat_is[11], rd);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        do_reset();
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0005);
        for (int k = 1; k <= 4; k++) tick();
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'd0 || estat_is[11] !== 1'b0) begin
            mismatched++; $display("FAIL one_zero got tval=%0d ti=%b exp tval=0 ti=0", rd, estat_is[11]);
        end
        tick();
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'hFFFF_FFFF || estat_is[11] !== 1'b1) begin
            mismatched++; $display("FAIL one_expire got tval=%h ti=%b exp tval=ffffffff ti=1", rd, estat_is[11]);
        end
        csr_write(CSR_TICLR, 32'h1, 32'h1);
        for (int k = 0; k < 10; k++) tick();
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'hFFFF_FFFF || estat_is[11] !== 1'b0) begin
            mismatched++; $display("FAIL one_done got tval=%h ti=%b exp tval=ffffffff ti=0", rd, estat_is[11]);
        end
    endtask

    task automatic test_ticlr();
        logic [31:0] rd;
        do_reset();
        crmd_ie  = 1'b1;
        ecfg_lie = 13'h800;
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0001);
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'd0 || estat_is[11] !== 1'b0) begin
            mismatched++; $display("FAIL init0_load got tval=%0d ti=%b exp tval=0 ti=0", rd, estat_is[11]);
        end
        tick();
        compared++;
        if (estat_is[11] !== 1'b1 || has_int !== 1'b1) begin
            mismatched++; $display("FAIL init0_int got ti=%b int=%b exp ti=1 int=1", estat_is[11], has_int);
        end
        csr_write(CSR_TICLR, 32'h0000_0001, 32'h0000_0001);
        compared++;
        if (estat_is[11] !== 1'b0 || has_int !== 1'b0) begin
            mismatched++; $display("FAIL ticlr got ti=%b int=%b exp ti=0 int=0", estat_is[11], has_int);
        end
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0005);
        for (int k = 0; k < 4; k++) tick();
        csr_write(CSR_TICLR, 32'h0000_0001, 32'h0000_0001);
        compared++;
        if (estat_is[11] !== 1'b1 || has_int !== 1'b1) begin
            mismatched++; $display("FAIL clr_vs_expire got ti=%b int=%b exp ti=1 int=1", estat_is[11], has_int);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        do_reset();
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0001);
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0009);
        read_csr(CSR_TVAL, rd);
        compared++;
        if (estat_is[11] !== 1'b1 || rd !== 32'd8) begin
            mismatched++; $display("FAIL wr_vs_expire got ti=%b tval=%0d exp ti=1 tval=8", estat_is[11], rd);
        end
        tick();
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'd7) begin mismatched++; $display("FAIL wr_vs_expire_next got tval=%0d exp 7", rd); end
    endtask

    task automatic test_hw_int();
        logic [31:0] rd;
        do_reset();
        hw_int_in = 8'h01;
        ecfg_lie  = 13'h004;
        tick();
        compared++;
        if (estat_is !== 13'h004 || has_int !== 1'b0) begin
            mismatched++; $display("FAIL hw_ie0 got is=%h int=%b exp is=004 int=0", estat_is, has_int);
        end
        crmd_ie = 1'b1;
        #1;
        compared++;
        if (has_int !== 1'b1) begin mismatched++; $display("FAIL hw_ie1 got int=%b exp 1", has_int); end
        hw_int_in = 8'h00;
        tick();
        compared++;
        if (estat_is !== 13'h000 || has_int !== 1'b0) begin
            mismatched++; $display("FAIL hw_release got is=%h int=%b exp is=000 int=0", estat_is, has_int);
        end
        csr_write(CSR_ESTAT, 32'h0000_0003, 32'h0000_0002);
        compared++;
        if (estat_is !== 13'h002) begin mismatched++; $display("FAIL sw_write got is=%h exp 002", estat_is); end
        ipi_int_in = 1'b1;
        ecfg_lie   = 13'h1000;
        csr_write(CSR_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        compared++;
        if (estat_is !== 13'h1001 || has_int !== 1'b1) begin
            mismatched++; $display("FAIL ipi_estat got is=%h int=%b exp is=1001 int=1", estat_is, has_int);
        end
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL estat_no_side got tval=%h exp ffffffff", rd); end
    endtask

    task automatic test_disable_and_reset();
        logic [31:0] rd;
        do_reset();
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
        for (int k = 0; k < 3; k++) tick();
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'd5) begin mismatched++; $display("FAIL dis_pre got tval=%0d exp 5", rd); end
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0008);
        for (int k = 0; k < 12; k++) tick();
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'd5 || estat_is[11] !== 1'b0) begin
            mismatched++; $display("FAIL dis_frozen got tval=%0d ti=%b exp tval=5 ti=0", rd, estat_is[11]);
        end
        csr_write(CSR_TID, 32'hFFFF_FFFF, 32'hCAFE_0001);
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0005);
        for (int k = 0; k < 5; k++) tick();
        compared++;
        if (estat_is[11] !== 1'b1) begin mismatched++; $display("FAIL pre_reset_ti got %b exp 1", estat_is[11]); end
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'hFFFF_FFFF || estat_is[11] !== 1'b0) begin
            mismatched++; $display("FAIL mid_reset got tval=%h ti=%b exp tval=ffffffff ti=0", rd, estat_is[11]);
        end
        read_csr(CSR_TID, rd);
        compared++;
        if (rd !== 32'h0) begin mismatched++; $display("FAIL mid_reset_tid got %h exp 0", rd); end
        for (int k = 0; k < 10; k++) tick();
        read_csr(CSR_TVAL, rd);
        compared++;
        if (rd !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL post_reset_idle got tval=%h exp ffffffff", rd); end
    endtask

    task automatic test_stable_cnt();
        logic [63:0] exp_cnt;
        do_reset();
`ifdef STABLE_COUNTER_EN
        exp_cnt = 64'd0;
`else
        exp_cnt = 64'd0;
`endif
        compared++;
        if (stable_cnt !== exp_cnt) begin mismatched++; $display("FAIL stable_k0 got %0d exp %0d", stable_cnt, exp_cnt); end
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef STABLE_COUNTER_EN
            exp_cnt = 64'(k);
`else
            exp_cnt = 64'd0;
`endif
            compared++;
            if (stable_cnt !== exp_cnt) begin
                mismatched++; $display("FAIL stable_k%0d got %0d exp %0d", k, stable_cnt, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_ticlr();
        test_back_to_back();
        test_hw_int();
        test_disable_and_reset();
        test_stable_cnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
